// File: rtl/seq_arith_shifter_if.sv
// Operand and result handshakes for seq_arith_shifter.
// The master modport is the producer/consumer side; slave is the shifter.
interface seq_arith_shifter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_signed;
  logic [SHAMT_W-1:0] in_amount;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_neg;

  modport master (
    output in_valid, in_data, in_signed, in_amount, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_amount, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/seq_arith_shifter.sv
// Iterative logical/arithmetic right shifter, one bit per cycle.
// Optional SEQ_ARITH_SHIFTER_EARLY_EXIT_EN stops as soon as the register is all fill bits.
module seq_arith_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  seq_arith_shifter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_neg_q, out_neg_d;
  logic             in_ready_q, in_ready_d;

  logic [CntW-1:0]  amt_clamped;
  logic [WIDTH-1:0] shifted;
  logic             all_fill;

  always_comb begin
    if (32'(bus.in_amount) >= WIDTH) begin
      amt_clamped = CntW'(WIDTH);
    end else begin
      amt_clamped = CntW'(bus.in_amount);
    end
  end

  assign shifted = {fill_q, data_q[WIDTH-1:1]};

`ifdef SEQ_ARITH_SHIFTER_EARLY_EXIT_EN
  // Further shifts cannot change a register that already holds only fill bits.
  assign all_fill = (data_q == {WIDTH{fill_q}});
`else
  assign all_fill = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    fill_d     = fill_q;
    out_data_d = out_data_q;
    out_neg_d  = out_neg_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          data_d   = bus.in_data;
          signed_d = bus.in_signed;
          fill_d   = bus.in_signed & bus.in_data[WIDTH-1];
          cnt_d    = amt_clamped;
          if (amt_clamped == '0) begin
            state_d    = StDone;
            out_data_d = bus.in_data;
            out_neg_d  = bus.in_data[WIDTH-1] & bus.in_signed;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (all_fill) begin
          state_d    = StDone;
          out_data_d = data_q;
          out_neg_d  = data_q[WIDTH-1] & signed_q;
        end else begin
          data_d = shifted;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d    = StDone;
            out_data_d = shifted;
            out_neg_d  = shifted[WIDTH-1] & signed_q;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered from next state so in_ready has no path from out_ready.
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      fill_q     <= 1'b0;
      out_data_q <= '0;
      out_neg_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      fill_q     <= fill_d;
      out_data_q <= out_data_d;
      out_neg_q  <= out_neg_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;
  assign bus.out_neg   = out_neg_q;

endmodule

// File: doc/seq_arith_shifter.md
# seq_arith_shifter

Iterative right shifter that applies a logical or arithmetic shift one bit position per cycle to an operand accepted over a valid/ready handshake. Signedness is selected per operation, mirroring Verilog `>>` / `>>>` semantics on unsigned and signed operands. The result is returned over a second valid/ready handshake. It sits in the datapath directly upstream of the consumer that compares signed and unsigned shift results.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default 6: shift-amount width. Amounts up to 2^SHAMT_W−1 are accepted.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand available.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  WIDTH  operand.
- `in_signed`  in  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill).
- `in_amount`  in  SHAMT_W  shift distance.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  shifted result.
- `out_neg`  out  1  equals `out_data[WIDTH-1] & latched in_signed`.

## Operation

- **States:** IDLE, SHIFT, DONE. The reset state is IDLE.
- **Reset values:** `in_ready`=1 and `out_valid`=0, with `out_data`, `out_neg`, the shift counter and the latched signed flag all 0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_data`, `in_signed` and the count n = min(`in_amount`, WIDTH).
  - The fill bit is `in_signed & in_data[WIDTH-1]`.
  - If n==0, go to DONE; otherwise go to SHIFT.
- **SHIFT:**
  - Each cycle: shift the data register right by 1, insert the fill bit at the MSB, and decrement the count.
  - When the count goes 1→0, go to DONE.
  - `in_ready`=0.
- **DONE:**
  - `out_valid`=1, and `out_data` is held stable.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_ready`=0. There is no bypass, so a new operand cannot be accepted in the same cycle as result acceptance.
- **Arithmetic rules:**
  - The fill bit is fixed at accept time.
  - Signed −1 stays at −1 for any amount.
  - Signed negative values with n ≥ WIDTH−1 yield all-ones.
  - Unsigned operands with n ≥ WIDTH yield 0.
  - Amounts greater than WIDTH are clamped to WIDTH, so the result equals the WIDTH result.
- **Backpressure:** `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- **Reset mid-operation:** `reset` in any state aborts the operation in flight. On the next edge all registers return to their reset values and the operand is discarded.

## Timing

- Operand accepted at the end of cycle k → `out_valid` first high in cycle k+1+n:
  - n=0 → k+1
  - n=1 → k+2
  - n=WIDTH → k+1+WIDTH
- **Throughput:** one operation per n+2 cycles at best (accept cycle, n shift cycles, one DONE cycle with `out_ready`=1).
- `out_data` and `out_neg` are registered and change only on the edge that enters DONE or on reset.
- `in_ready` is a registered function of the state only. It has no combinational path from `out_ready`.

## Configuration

- **Macro:** `SEQ_ARITH_SHIFTER_EARLY_EXIT_EN`.
- **Defined:**
  - In SHIFT, before shifting, if every bit of the data register equals the fill bit, go directly to DONE that cycle with the register unchanged.
  - Result values are identical to the non-EN build; only latency shrinks.
  - Latency becomes k+1+min(n, s+1), where s is the number of shifts needed to reach all-fill.
- **Undefined:** latency is always k+1+n, regardless of data.

## Test plan

Benches use WIDTH=32.

1. **Signed −1 shift:** `in_data`=0xFFFFFFFF, `in_signed`=1, `in_amount`=1 → `out_data`=0xFFFFFFFF, `out_neg`=1, `out_valid` in cycle k+2.
2. **Unsigned −1 shift:** `in_data`=0xFFFFFFFF, `in_signed`=0, `in_amount`=1 → `out_data`=0x7FFFFFFF, `out_neg`=0, `out_valid` in cycle k+2.
3. **Clamped amount:** `in_data`=0x00000001, `in_signed`=0, `in_amount`=40 → `out_data`=0.
   - `out_valid` in cycle k+33 without the macro.
   - `out_valid` in cycle k+3 with `SEQ_ARITH_SHIFTER_EARLY_EXIT_EN`.
4. **Zero amount:** `in_data`=0x80000000, `in_signed`=1, `in_amount`=0 → `out_data`=0x80000000 and `out_neg`=1 in cycle k+1.
   - Then `in_amount`=4 on the same operand → 0xF8000000.
5. **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid` rises → `out_data` stable and `in_ready`=0 throughout, with `in_valid` pulses ignored.
   - Raising `out_ready` returns the block to IDLE, with `in_ready`=1 next cycle.
6. **Reset mid-shift:** `reset` asserted 3 cycles into a 20-bit shift → next cycle IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0.
   - No stale result appears afterwards.
